i2c_master_driver: RTL and testbench

- Transaction sequencer on the user side of the I2C master core: it drives the core's start/send/receive handshakes the way the slave driver serves the slave core.
- Accepts one register-level command (device address, register pointer, 0..4 data bytes, read or write) and executes it as one or two I2C transactions through the master core.
- Returns read data, completion status and an error code to a host FSM, e.g. a BMP180 polling loop.

---
 rtl/i2c_drv_pkg.sv | 33 +++
 rtl/i2c_drv_watchdog.sv | 28 ++
 rtl/i2c_master_driver.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_master_driver.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_drv_pkg.sv
// Shared types and constants for the I2C master transaction driver.
// State encoding, error codes, RW bit values and byte count limits.
package i2c_drv_pkg;

   localparam int MAXLEN = 4;
   localparam logic [2:0] MAXLEN_L = 3'(MAXLEN);

   typedef enum logic [3:0] {
      IDLE,
      WSTART,
      WADDR,
      WREG,
      WDATA,
      RSTART,
      RADDR,
      RDATA,
      FIN
   } state_t;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_ANACK = 2'b01;
   localparam logic [1:0] ERR_DNACK = 2'b10;
   localparam logic [1:0] ERR_TMO   = 2'b11;

   localparam logic I2C_WR = 1'b0;
   localparam logic I2C_RD = 1'b1;

   // Oversized byte counts saturate at the data bus capacity.
   function automatic logic [2:0] clamp_len(input logic [2:0] l);
      return (l > MAXLEN_L) ? MAXLEN_L : l;
   endfunction

endpackage

// File: rtl/i2c_drv_watchdog.sv
// Idle-handshake watchdog for the I2C master driver.
// Counts enabled cycles and flags when TIMEOUT cycles pass without a clear.
module i2c_drv_watchdog #(
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [15:0] cnt;

   // Cycle counter, restarted by any handshake event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 16'd1;
      end
   end

   assign tc = en && !clr && (cnt >= TIMEOUT - 16'd1);

endmodule

// File: rtl/i2c_master_driver.sv
// Register-level command sequencer on the user side of the I2C master core.
// Runs one write or write-then-read transaction pair per accepted command.
module i2c_master_driver
   import i2c_drv_pkg::*;
#(
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_rw,
   input  logic [6:0]            cmd_dev,
   input  logic [7:0]            cmd_reg,
   input  logic [2:0]            cmd_len,
   input  logic [8*MAXLEN-1:0]   wr_data,
   output logic [8*MAXLEN-1:0]   rd_data,
   output logic                  done,
   output logic [1:0]            err,
   output logic                  start,
   input  logic                  ready,
   input  logic                  send,
   output logic [7:0]            datasend,
   input  logic                  sended,
   input  logic                  nack,
   input  logic                  receive,
   input  logic [7:0]            datareceive,
   input  logic                  received,
   output logic                  last
);

   state_t               state;
   logic                 rw_q;
   logic [6:0]           dev_q;
   logic [7:0]           reg_q;
   logic [2:0]           len_q;
   logic [8*MAXLEN-1:0]  wdat_q;
   logic [2:0]           k;
   logic [2:0]           next_k;
   logic                 last_k;
   logic                 tmo;
   logic                 wd_en;
   logic                 wd_clr;
   logic                 unused_in;

   // The byte phase flags carry no extra information for this sequencer.
   assign unused_in = send ^ receive;

   assign next_k = k + 3'd1;
   assign last_k = (k == len_q - 3'd1);
   assign wd_en  = (state != IDLE);
   assign wd_clr = !wd_en || start || sended || received || nack;

   i2c_drv_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wd (
      .clk   (clk),
      .reset (reset),
      .clr   (wd_clr),
      .en    (wd_en),
      .tc    (tmo)
   );

   // Command sequencer with registered core handshakes and status.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         start     <= 1'b0;
         done      <= 1'b0;
         err       <= ERR_OK;
         last      <= 1'b0;
         datasend  <= 8'h00;
         rd_data   <= '0;
         rw_q      <= 1'b0;
         dev_q     <= 7'h00;
         reg_q     <= 8'h00;
         len_q     <= 3'd0;
         wdat_q    <= '0;
         k         <= 3'd0;
      end else begin
         start <= 1'b0;
         done  <= 1'b0;
         if (tmo) begin
            err   <= ERR_TMO;
            done  <= 1'b1;
            last  <= 1'b0;
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  cmd_ready <= 1'b1;
                  if (cmd_valid && cmd_ready) begin
                     cmd_ready <= 1'b0;
                     rw_q      <= cmd_rw;
                     dev_q     <= cmd_dev;
                     reg_q     <= cmd_reg;
                     len_q     <= clamp_len(cmd_len);
                     wdat_q    <= wr_data;
                     err       <= ERR_OK;
                     k         <= 3'd0;
                     if (cmd_rw == I2C_RD) rd_data <= '0;
                     state     <= WSTART;
                  end
               end
               WSTART: begin
                  if (ready) begin
                     start    <= 1'b1;
                     datasend <= {dev_q, I2C_WR};
                     last     <= 1'b0;
                     state    <= WADDR;
                  end
               end
               WADDR: begin
                  if (nack) begin
                     err   <= ERR_ANACK;
                     last  <= 1'b0;
                     state <= FIN;
                  end else if (sended) begin
                     datasend <= reg_q;
                     last     <= (rw_q == I2C_RD) || (len_q == 3'd0);
                     state    <= WREG;
                  end
               end
               WREG: begin
                  if (nack) begin
                     err   <= ERR_DNACK;
                     last  <= 1'b0;
                     state <= FIN;
                  end else if (sended) begin
                     last <= 1'b0;
                     k    <= 3'd0;
                     if (len_q == 3'd0) begin
                        state <= FIN;
                     end else if (rw_q == I2C_RD) begin
                        state <= RSTART;
                     end else begin
                        datasend <= wdat_q[7:0];
                        last     <= (len_q == 3'd1);
                        state    <= WDATA;
                     end
                  end
               end
               WDATA: begin
                  if (nack) begin
                     err   <= ERR_DNACK;
                     last  <= 1'b0;
                     state <= FIN;
                  end else if (sended) begin
                     if (last_k) begin
                        last  <= 1'b0;
                        state <= FIN;
                     end else begin
                        k        <= next_k;
                        datasend <= wdat_q[{next_k[1:0], 3'b000} +: 8];
                        last     <= (next_k == len_q - 3'd1);
                     end
                  end
               end
               RSTART: begin
                  if (ready) begin
                     start    <= 1'b1;
                     datasend <= {dev_q, I2C_RD};
                     last     <= 1'b0;
                     state    <= RADDR;
                  end
               end
               RADDR: begin
                  if (nack) begin
                     err   <= ERR_ANACK;
                     last  <= 1'b0;
                     state <= FIN;
                  end else if (sended) begin
                     k     <= 3'd0;
                     last  <= (len_q == 3'd1);
                     state <= RDATA;
                  end
               end
               RDATA: begin
                  if (received) begin
                     rd_data[{k[1:0], 3'b000} +: 8] <= datareceive;
                     if (last_k) begin
                        last  <= 1'b0;
                        state <= FIN;
                     end else begin
                        k    <= next_k;
                        last <= (next_k == len_q - 3'd1);
                     end
                  end
               end
               FIN: begin
                  last <= 1'b0;
                  if (ready) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_master_driver.sv
// Self-checking bench for i2c_master_driver with a behavioural core model.
// Expected byte/last pairs are queued per command and consumed by the core.
module tb_i2c_master_driver;
   import i2c_drv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_rw;
   logic [6:0]  cmd_dev;
   logic [7:0]  cmd_reg;
   logic [2:0]  cmd_len;
   logic [31:0] wr_data, rd_data;
   logic        done;
   logic [1:0]  err;
   logic        start, ready, send, sended, nack;
   logic        receive, received, last;
   logic [7:0]  datasend, datareceive;

   i2c_master_driver #(.TIMEOUT(16'd100)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_len(cmd_len),
      .wr_data(wr_data), .rd_data(rd_data),
      .done(done), .err(err), .start(start), .ready(ready),
      .send(send), .datasend(datasend), .sended(sended), .nack(nack),
      .receive(receive), .datareceive(datareceive),
      .received(received), .last(last)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int starts = 0;
   int start_cyc = 0;
   int nack_at = -1;
   bit hang = 1'b0;
   logic [8:0] exp_q[$];
   logic [7:0] rx_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic sb_pop(input string tag, input logic [8:0] obs);
      logic [8:0] e;
      if (exp_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: got %h expected nothing", tag, obs);
      end else begin
         e = exp_q.pop_front();
         chk(tag, 32'(obs), 32'(e));
      end
   endtask

   task automatic run_txn();
      logic rd;
      bit   fin;
      int   b;
      rd = 1'b0;
      fin = 1'b0;
      b = 0;
      ready = 1'b0;
      while (!fin) begin
         repeat (2) @(negedge clk);
         if (!reset) break;
         if (rd && b > 0) begin
            receive = 1'b1;
            @(negedge clk);
            if (!reset) break;
            datareceive = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
            received = 1'b1;
            sb_pop("rx_byte", {last, datareceive});
            fin = last;
            @(negedge clk);
            received = 1'b0;
            receive = 1'b0;
         end else begin
            send = 1'b1;
            @(negedge clk);
            if (!reset) break;
            sb_pop("tx_byte", {last, datasend});
            if (b == 0) rd = datasend[0];
            if (b == nack_at) begin
               nack = 1'b1;
               fin = 1'b1;
            end else begin
               sended = 1'b1;
               fin = last;
            end
            @(negedge clk);
            nack = 1'b0;
            sended = 1'b0;
            send = 1'b0;
         end
         b++;
      end
      send = 1'b0;
      sended = 1'b0;
      nack = 1'b0;
      receive = 1'b0;
      received = 1'b0;
      repeat (3) @(negedge clk);
      ready = 1'b1;
   endtask

   initial begin : core
      ready = 1'b1;
      send = 1'b0;
      sended = 1'b0;
      nack = 1'b0;
      receive = 1'b0;
      received = 1'b0;
      datareceive = 8'h00;
      forever begin
         @(negedge clk);
         if (reset && start) begin
            starts++;
            start_cyc = cyc;
            if (hang) begin
               ready = 1'b0;
               while (hang) @(negedge clk);
               ready = 1'b1;
            end else begin
               run_txn();
            end
         end
      end
   end

   task automatic issue(input logic rw, input logic [6:0] dev,
                        input logic [7:0] rg, input logic [2:0] len,
                        input logic [31:0] wd);
      int i;
      i = 0;
      @(negedge clk);
      while (!cmd_ready && i < 500) begin
         @(negedge clk);
         i++;
      end
      chk("issue_ready", 32'(cmd_ready), 32'd1);
      cmd_rw = rw;
      cmd_dev = dev;
      cmd_reg = rg;
      cmd_len = len;
      wr_data = wd;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("accept_busy", 32'(cmd_ready), 32'd0);
   endtask

   task automatic wait_done(input int budget, input logic [1:0] exp_err,
                            output int at);
      bit seen;
      int extra;
      seen = 1'b0;
      extra = 0;
      at = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (done) begin
            seen = 1'b1;
            at = cyc;
            chk("err_at_done", 32'(err), 32'(exp_err));
         end else begin
            @(negedge clk);
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
      repeat (4) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk("done_once", 32'(extra), 32'd0);
      chk("err_held", 32'(err), 32'(exp_err));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      int at;
      int i;
      int d;
      int lat;
      cmd_valid = 1'b0;
      cmd_rw = 1'b0;
      cmd_dev = 7'h00;
      cmd_reg = 8'h00;
      cmd_len = 3'd0;
      wr_data = 32'h0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_last", 32'(last), 32'd0);
      chk("rst_datasend", 32'(datasend), 32'h00);
      chk("rst_rd_data", rd_data, 32'h0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // single-byte write
      starts = 0;
      exp_q.push_back({1'b0, 8'hEE});
      exp_q.push_back({1'b0, 8'hF4});
      exp_q.push_back({1'b1, 8'h2E});
      issue(I2C_WR, 7'h77, 8'hF4, 3'd1, 32'h0000_002E);
      wait_done(400, ERR_OK, at);
      chk("wr1_starts", 32'(starts), 32'd1);
      chk("wr1_drain", 32'(exp_q.size()), 32'd0);

      // two-byte read
      starts = 0;
      rx_q.push_back(8'h5A);
      rx_q.push_back(8'hC3);
      exp_q.push_back({1'b0, 8'hEE});
      exp_q.push_back({1'b1, 8'hF6});
      exp_q.push_back({1'b0, 8'hEF});
      exp_q.push_back({1'b0, 8'h5A});
      exp_q.push_back({1'b1, 8'hC3});
      issue(I2C_RD, 7'h77, 8'hF6, 3'd2, 32'h0);
      wait_done(600, ERR_OK, at);
      chk("rd2_starts", 32'(starts), 32'd2);
      chk("rd2_data", rd_data, 32'h0000_C35A);
      chk("rd2_drain", 32'(exp_q.size()), 32'd0);

      // zero-length read
      starts = 0;
      exp_q.push_back({1'b0, 8'hEE});
      exp_q.push_back({1'b1, 8'hF6});
      issue(I2C_RD, 7'h77, 8'hF6, 3'd0, 32'h0);
      wait_done(400, ERR_OK, at);
      chk("rd0_starts", 32'(starts), 32'd1);
      chk("rd0_data", rd_data, 32'h0);
      chk("rd0_drain", 32'(exp_q.size()), 32'd0);

      // oversized length clamps to four bytes
      exp_q.push_back({1'b0, 8'hEE});
      exp_q.push_back({1'b0, 8'h10});
      exp_q.push_back({1'b0, 8'h11});
      exp_q.push_back({1'b0, 8'h22});
      exp_q.push_back({1'b0, 8'h33});
      exp_q.push_back({1'b1, 8'h44});
      issue(I2C_WR, 7'h77, 8'h10, 3'd7, 32'h4433_2211);
      wait_done(600, ERR_OK, at);
      chk("clamp_drain", 32'(exp_q.size()), 32'd0);

      // address NACK
      nack_at = 0;
      exp_q.push_back({1'b0, 8'hEE});
      issue(I2C_WR, 7'h77, 8'hF4, 3'd2, 32'h0000_2211);
      wait_done(400, ERR_ANACK, at);
      chk("anack_drain", 32'(exp_q.size()), 32'd0);
      chk("anack_ready", 32'(cmd_ready), 32'd1);

      // data NACK on first data byte
      nack_at = 2;
      exp_q.push_back({1'b0, 8'hEE});
      exp_q.push_back({1'b0, 8'hF4});
      exp_q.push_back({1'b0, 8'h11});
      issue(I2C_WR, 7'h77, 8'hF4, 3'd2, 32'h0000_2211);
      wait_done(400, ERR_DNACK, at);
      chk("dnack_drain", 32'(exp_q.size()), 32'd0);
      nack_at = -1;

      // core stalls after start, busy command ignored
      starts = 0;
      hang = 1'b1;
      issue(I2C_WR, 7'h77, 8'hF4, 3'd1, 32'h0000_002E);
      repeat (20) @(negedge clk);
      cmd_rw = I2C_RD;
      cmd_dev = 7'h11;
      cmd_valid = 1'b1;
      repeat (5) @(negedge clk);
      cmd_valid = 1'b0;
      wait_done(300, ERR_TMO, at);
      lat = at - start_cyc;
      chk("tmo_latency", 32'(lat >= 98 && lat <= 103), 32'd1);
      chk("tmo_starts", 32'(starts), 32'd1);
      chk("tmo_ready", 32'(cmd_ready), 32'd1);
      hang = 1'b0;
      repeat (3) @(negedge clk);

      // reset in the middle of the data phase
      exp_q.push_back({1'b0, 8'hEE});
      exp_q.push_back({1'b0, 8'hF4});
      exp_q.push_back({1'b0, 8'hA1});
      exp_q.push_back({1'b0, 8'hB2});
      exp_q.push_back({1'b0, 8'hC3});
      exp_q.push_back({1'b1, 8'hD4});
      issue(I2C_WR, 7'h77, 8'hF4, 3'd4, 32'hD4C3_B2A1);
      i = 0;
      while (exp_q.size() > 4 && i < 300) begin
         @(negedge clk);
         i++;
      end
      chk("reach_wdata", 32'(exp_q.size() <= 4), 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mrst_start", 32'(start), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_ready", 32'(cmd_ready), 32'd1);
      d = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) d++;
      end
      chk("mrst_no_done", 32'(d), 32'd0);
      exp_q.delete();
      reset = 1'b1;
      repeat (8) @(negedge clk);

      starts = 0;
      exp_q.push_back({1'b0, 8'hEE});
      exp_q.push_back({1'b0, 8'hF4});
      exp_q.push_back({1'b1, 8'h5C});
      issue(I2C_WR, 7'h77, 8'hF4, 3'd1, 32'h0000_005C);
      wait_done(400, ERR_OK, at);
      chk("post_starts", 32'(starts), 32'd1);
      chk("post_drain", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
